ram_port_arbiter: RTL

Arbiter and sequencer for the single-port instruction/data RAM behind the LSU. It shares that port between three requesters: the host loader, the data path (LW/SW) and instruction fetch. It registers the winning command onto the RAM and routes synchronous read data back to its owner with a valid strobe. A starvation guard keeps fetch from being locked out by back-to-back LW/SW traffic.

---
 rtl/ram_port_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Three-way arbiter for the single-port instruction/data RAM: host > data > fetch,
// with a starvation guard that lifts fetch above data, and owner-tagged read return.
module ram_port_arbiter #(
    parameter int AW         = 9,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          working,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_HOST  = 2'd1,
        OWN_DATA  = 2'd2,
        OWN_FETCH = 2'd3
    } owner_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic          ram_en_q, ram_en_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    owner_e        own_q, own_d;
    owner_e        rd_own_q, rd_own_d;
    logic [3:0]    starve_q, starve_d;

    logic promote;
    logic core_ok;

    // Grants are combinational and gated by reset so nothing is granted while it is held.
    always_comb begin
        promote = (starve_q == STARVE_LIM);
        core_ok = reset & working & ~h_req;
        h_gnt   = reset & h_req;
        f_gnt   = core_ok & f_req & (promote | ~d_req);
        d_gnt   = core_ok & d_req & ~f_gnt;
    end

    always_comb begin
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        own_d       = OWN_NONE;
        if (h_gnt) begin
            ram_en_d    = 1'b1;
            ram_we_d    = h_we;
            ram_addr_d  = h_addr;
            ram_wdata_d = h_we ? h_wdata : '0;
            own_d       = OWN_HOST;
        end else if (d_gnt) begin
            ram_en_d    = 1'b1;
            ram_we_d    = d_we;
            ram_addr_d  = d_addr;
            ram_wdata_d = d_we ? d_wdata : '0;
            own_d       = OWN_DATA;
        end else if (f_gnt) begin
            ram_en_d    = 1'b1;
            ram_addr_d  = f_addr;
            ram_wdata_d = '0;
            own_d       = OWN_FETCH;
        end
    end

    // Only reads carry their owner into the return stage; writes retire silently.
    always_comb begin
        rd_own_d = OWN_NONE;
        if (ram_en_q && !ram_we_q) begin
            rd_own_d = own_q;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (working) begin
            if (f_gnt || !f_req) begin
                starve_d = 4'd0;
            end else if (starve_q < STARVE_LIM) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            own_q       <= OWN_NONE;
            rd_own_q    <= OWN_NONE;
            starve_q    <= 4'd0;
        end else begin
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            own_q       <= own_d;
            rd_own_q    <= rd_own_d;
            starve_q    <= starve_d;
        end
    end

    always_comb begin
        ram_en    = ram_en_q;
        ram_we    = ram_we_q;
        ram_addr  = ram_addr_q;
        ram_wdata = ram_wdata_q;
        h_rvalid  = (rd_own_q == OWN_HOST);
        d_rvalid  = (rd_own_q == OWN_DATA);
        f_rvalid  = (rd_own_q == OWN_FETCH);
        rdata     = (rd_own_q != OWN_NONE) ? ram_rdata : '0;
        busy      = ram_en_q | (rd_own_q != OWN_NONE);
    end

endmodule
